// File: rtl/seizure_detect.sv
// Seizure detector: a registered threshold compare (feat vs. scaled baseline) feeding an
// onset/offset hysteresis FSM with a saturating onset counter.
module seizure_detect #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BASE_WIDTH = 32,
    parameter int unsigned THR_K      = 12,
    parameter int unsigned FRAC_BITS  = 2,
    parameter int unsigned ONSET_CNT  = 4,
    parameter int unsigned OFFSET_CNT = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] feat,
    input  logic signed [BASE_WIDTH-1:0] base,
    output logic                         seizure,
    output logic                         onset,
    output logic                         offset,
    output logic [1:0]                   state,
    output logic [15:0]                  event_cnt
);
    localparam int unsigned CmpW   = BASE_WIDTH + 9;
    localparam int unsigned MaxCnt = (ONSET_CNT > OFFSET_CNT) ? ONSET_CNT : OFFSET_CNT;
    localparam int unsigned RunW   = $clog2(MaxCnt) + 1;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StOnPend  = 2'd1,
        StSeiz    = 2'd2,
        StOffPend = 2'd3
    } state_e;

    logic signed [CmpW-1:0] lhs;
    logic signed [CmpW-1:0] rhs;
    logic                   exc_q;
    logic                   v1_q;
    state_e                 st_q;
    logic [RunW-1:0]        run_q;
    logic [RunW-1:0]        run_inc;
    logic                   at_onset;
    logic                   at_offset;

    // Both sides widened before scaling so the compare is exact for any signed base.
    assign lhs = CmpW'(feat) <<< FRAC_BITS;
    assign rhs = CmpW'(base) * $signed(CmpW'(THR_K));

    assign run_inc   = run_q + RunW'(1);
    assign at_onset  = (run_inc == RunW'(ONSET_CNT));
    assign at_offset = (run_inc == RunW'(OFFSET_CNT));

    assign state   = st_q;
    assign seizure = (st_q == StSeiz) || (st_q == StOffPend);

    always_ff @(posedge clk) begin
        if (rst) begin
            exc_q <= 1'b0;
            v1_q  <= 1'b0;
        end else begin
            v1_q <= en;
            if (en) begin
                exc_q <= (lhs > rhs);
            end
        end
    end

    // run_q is always zero in StIdle and StSeiz, so pending and settled states share branches.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q      <= StIdle;
            run_q     <= '0;
            onset     <= 1'b0;
            offset    <= 1'b0;
            event_cnt <= 16'd0;
        end else begin
            onset  <= 1'b0;
            offset <= 1'b0;
            if (v1_q) begin
                unique case (st_q)
                    StIdle, StOnPend: begin
                        if (exc_q) begin
                            if (at_onset) begin
                                st_q  <= StSeiz;
                                run_q <= '0;
                                onset <= 1'b1;
                                if (event_cnt != 16'hFFFF) begin
                                    event_cnt <= event_cnt + 16'd1;
                                end
                            end else begin
                                st_q  <= StOnPend;
                                run_q <= run_inc;
                            end
                        end else begin
                            st_q  <= StIdle;
                            run_q <= '0;
                        end
                    end
                    StSeiz, StOffPend: begin
                        if (!exc_q) begin
                            if (at_offset) begin
                                st_q   <= StIdle;
                                run_q  <= '0;
                                offset <= 1'b1;
                            end else begin
                                st_q  <= StOffPend;
                                run_q <= run_inc;
                            end
                        end else begin
                            st_q  <= StSeiz;
                            run_q <= '0;
                        end
                    end
                endcase
            end
        end
    end

endmodule
